// File: rtl/servo_scan_if.sv
// Bundle of the scan controller's control and measurement signals.
// The master side is the scan controller itself (it owns meas_req and the
// reported angle); the slave side is the environment that supplies the
// enable and the ranging unit's completion strobe.
interface servo_scan_if #(
    parameter int POS_LEN = 8
);
    logic               en;
    logic               meas_done;
    logic [POS_LEN-1:0] pos;
    logic               dir;
    logic               meas_req;
    logic [POS_LEN-1:0] angle;
    logic               angle_valid;
    logic               timeout;
    logic               sweep_done;

    modport master (
        input  en,
        input  meas_done,
        output pos,
        output dir,
        output meas_req,
        output angle,
        output angle_valid,
        output timeout,
        output sweep_done
    );

    modport slave (
        output en,
        output meas_done,
        input  pos,
        input  dir,
        input  meas_req,
        input  angle,
        input  angle_valid,
        input  timeout,
        input  sweep_done
    );
endinterface

// File: rtl/servo_scan.sv
// Servo sweep controller: steps the commanded angle back and forth between
// POS_MIN and POS_MAX, lets the servo settle at each angle, then runs one
// request/done handshake with the ranging unit and reports the angle that
// belongs to the completed measurement. Every output comes from a flop.
module servo_scan #(
    parameter int POS_LEN     = 8,
    parameter int POS_MIN     = 0,
    parameter int POS_MAX     = 180,
    parameter int STEP        = 1,
    parameter int CNT_LEN     = 24,
    parameter int SETTLE_CYC  = 5000000,
    parameter int TIMEOUT_CYC = 2500000
) (
    input  logic          clk,
    input  logic          rst,
    servo_scan_if.master  bus
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_MEAS,
        S_STEP
    } state_t;

    // Position arithmetic uses one extra bit so pos+STEP and pos-STEP can
    // be compared against the end points without wrapping.
    typedef logic [POS_LEN:0] wide_t;

    localparam wide_t               STEP_W      = wide_t'(STEP);
    localparam wide_t               POS_MAX_W   = wide_t'(POS_MAX);
    localparam wide_t               LOW_LIMIT_W = wide_t'(POS_MIN + STEP);
    localparam logic [POS_LEN-1:0]  POS_RESET   = POS_LEN'(POS_MIN);
    localparam logic [CNT_LEN-1:0]  SETTLE_LAST = CNT_LEN'(SETTLE_CYC - 1);
    localparam logic [CNT_LEN-1:0]  MEAS_LAST   = CNT_LEN'(TIMEOUT_CYC - 1);
    localparam logic [CNT_LEN-1:0]  CNT_ONE     = CNT_LEN'(1);

    state_t             state_q, state_d;
    logic [POS_LEN-1:0] pos_q, pos_d;
    logic               dir_q, dir_d;
    logic [POS_LEN-1:0] angle_q, angle_d;
    logic [CNT_LEN-1:0] cnt_q, cnt_d;
    logic               meas_req_q, meas_req_d;
    logic               angle_valid_q, angle_valid_d;
    logic               timeout_q, timeout_d;
    logic               sweep_done_q, sweep_done_d;

    wide_t pos_wide;
    wide_t pos_up;
    wide_t pos_dn;

    assign pos_wide = {1'b0, pos_q};
    assign pos_up   = pos_wide + STEP_W;
    assign pos_dn   = pos_wide - STEP_W;

    // Register bank; reset parks the sweep at POS_MIN heading upward and
    // withdraws any outstanding measurement request immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            pos_q         <= POS_RESET;
            dir_q         <= 1'b0;
            angle_q       <= '0;
            cnt_q         <= '0;
            meas_req_q    <= 1'b0;
            angle_valid_q <= 1'b0;
            timeout_q     <= 1'b0;
            sweep_done_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            pos_q         <= pos_d;
            dir_q         <= dir_d;
            angle_q       <= angle_d;
            cnt_q         <= cnt_d;
            meas_req_q    <= meas_req_d;
            angle_valid_q <= angle_valid_d;
            timeout_q     <= timeout_d;
            sweep_done_q  <= sweep_done_d;
        end
    end

    // Next-state and next-output logic for the settle/measure/step cycle.
    always_comb begin
        state_d       = state_q;
        pos_d         = pos_q;
        dir_d         = dir_q;
        angle_d       = angle_q;
        cnt_d         = cnt_q;
        meas_req_d    = 1'b0;
        angle_valid_d = 1'b0;
        timeout_d     = 1'b0;
        sweep_done_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.en) begin
                    state_d = S_SETTLE;
                    cnt_d   = '0;
                end
            end

            S_SETTLE: begin
                if (!bus.en) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == SETTLE_LAST) begin
                    state_d    = S_MEAS;
                    cnt_d      = '0;
                    meas_req_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end

            S_MEAS: begin
                // Enable is deliberately ignored so a handshake always
                // completes or times out; done wins over a coincident timeout.
                if (bus.meas_done) begin
                    state_d       = S_STEP;
                    cnt_d         = '0;
                    angle_d       = pos_q;
                    angle_valid_d = 1'b1;
                end else if (cnt_q == MEAS_LAST) begin
                    state_d   = S_STEP;
                    cnt_d     = '0;
                    timeout_d = 1'b1;
                end else begin
                    cnt_d      = cnt_q + CNT_ONE;
                    meas_req_d = 1'b1;
                end
            end

            S_STEP: begin
                // Reversal moves one step back from the end point so each
                // end point is measured once per pass, not twice.
                if (!dir_q) begin
                    if (pos_up <= POS_MAX_W) begin
                        pos_d = pos_up[POS_LEN-1:0];
                    end else begin
                        dir_d        = 1'b1;
                        pos_d        = pos_dn[POS_LEN-1:0];
                        sweep_done_d = 1'b1;
                    end
                end else begin
                    if (pos_wide >= LOW_LIMIT_W) begin
                        pos_d = pos_dn[POS_LEN-1:0];
                    end else begin
                        dir_d        = 1'b0;
                        pos_d        = pos_up[POS_LEN-1:0];
                        sweep_done_d = 1'b1;
                    end
                end
                cnt_d   = '0;
                state_d = bus.en ? S_SETTLE : S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign bus.pos         = pos_q;
    assign bus.dir         = dir_q;
    assign bus.meas_req    = meas_req_q;
    assign bus.angle       = angle_q;
    assign bus.angle_valid = angle_valid_q;
    assign bus.timeout     = timeout_q;
    assign bus.sweep_done  = sweep_done_q;

endmodule

// File: tb/tb_servo_scan.sv
// Testbench for servo_scan with a small sweep (0..4 step 2, settle 3,
// timeout 8). A behavioural model predicts every output each cycle while
// directed and randomized phases exercise the sweep, timeouts, enable
// drops, reset during a request and stray done pulses.
module tb_servo_scan;

    localparam int POS_LEN     = 8;
    localparam int POS_MIN     = 0;
    localparam int POS_MAX     = 4;
    localparam int STEP        = 2;
    localparam int CNT_LEN     = 8;
    localparam int SETTLE_CYC  = 3;
    localparam int TIMEOUT_CYC = 8;

    localparam int PH_IDLE   = 0;
    localparam int PH_SETTLE = 1;
    localparam int PH_MEAS   = 2;
    localparam int PH_STEP   = 3;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic enDrv = 1'b0;
    logic doneDrv = 1'b0;

    int nAsserts = 0;
    int nFails = 0;
    bit compareOn = 1'b0;

    // responder: 0 = answer respDelay cycles after request, 1 = never,
    // 3 = random done noise every cycle
    int respMode = 0;
    int respDelay = 2;
    int reqAge = 0;

    int angleLog[$];
    int sweepCount = 0;

    // behavioural model state
    int mPhase = PH_IDLE;
    int mSettleLeft = 0;
    int mMeasAge = 0;
    int mPos = POS_MIN;
    int mDir = 0;
    int mReq = 0;
    int mAngle = 0;
    int mValid = 0;
    int mTimeout = 0;
    int mSweep = 0;

    servo_scan_if #(.POS_LEN(POS_LEN)) bus();

    assign bus.en        = enDrv;
    assign bus.meas_done = doneDrv;

    servo_scan #(
        .POS_LEN    (POS_LEN),
        .POS_MIN    (POS_MIN),
        .POS_MAX    (POS_MAX),
        .STEP       (STEP),
        .CNT_LEN    (CNT_LEN),
        .SETTLE_CYC (SETTLE_CYC),
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        nAsserts++;
        if (actual !== expected) begin
            nFails++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic enVal);
        @(posedge clk);
        #1;
        enDrv = enVal;
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic waitReq(input logic level, input int budget, input string name);
        int n = 0;
        while (bus.meas_req !== level && n < budget) begin
            @(negedge clk);
            n++;
        end
        checkOutput(name, 32'(bus.meas_req), 32'(level));
    endtask

    // Ranging unit stand-in; changes meas_done shortly after each edge.
    always @(posedge clk) begin
        #1;
        case (respMode)
            0: begin
                if (bus.meas_req === 1'b1) begin
                    reqAge++;
                    doneDrv = (reqAge >= respDelay);
                end else begin
                    reqAge  = 0;
                    doneDrv = 1'b0;
                end
            end
            3: begin
                reqAge  = 0;
                doneDrv = ($urandom_range(0, 3) == 0);
            end
            default: begin
                reqAge  = 0;
                doneDrv = 1'b0;
            end
        endcase
    end

    // Behavioural model: the sweep as a cycle of settle countdown,
    // measurement age and a reflecting step, in plain integer arithmetic.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mPhase   = PH_IDLE;
            mPos     = POS_MIN;
            mDir     = 0;
            mReq     = 0;
            mAngle   = 0;
            mValid   = 0;
            mTimeout = 0;
            mSweep   = 0;
        end else begin
            mValid   = 0;
            mTimeout = 0;
            mSweep   = 0;
            case (mPhase)
                PH_IDLE: begin
                    if (bus.en) begin
                        mPhase      = PH_SETTLE;
                        mSettleLeft = SETTLE_CYC;
                    end
                end
                PH_SETTLE: begin
                    if (!bus.en) begin
                        mPhase = PH_IDLE;
                    end else begin
                        mSettleLeft--;
                        if (mSettleLeft == 0) begin
                            mPhase   = PH_MEAS;
                            mMeasAge = 0;
                            mReq     = 1;
                        end
                    end
                end
                PH_MEAS: begin
                    mMeasAge++;
                    if (bus.meas_done) begin
                        mAngle = mPos;
                        mValid = 1;
                        mReq   = 0;
                        mPhase = PH_STEP;
                    end else if (mMeasAge == TIMEOUT_CYC) begin
                        mTimeout = 1;
                        mReq     = 0;
                        mPhase   = PH_STEP;
                    end
                end
                default: begin
                    if (mDir == 0) begin
                        if (mPos + STEP <= POS_MAX) mPos = mPos + STEP;
                        else begin
                            mDir   = 1;
                            mPos   = mPos - STEP;
                            mSweep = 1;
                        end
                    end else begin
                        if (mPos - STEP >= POS_MIN) mPos = mPos - STEP;
                        else begin
                            mDir   = 0;
                            mPos   = mPos + STEP;
                            mSweep = 1;
                        end
                    end
                    if (bus.en) begin
                        mPhase      = PH_SETTLE;
                        mSettleLeft = SETTLE_CYC;
                    end else begin
                        mPhase = PH_IDLE;
                    end
                end
            endcase
        end
    end

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        if (compareOn) begin
            checkOutput("model pos", 32'(bus.pos), mPos);
            checkOutput("model dir", 32'(bus.dir), mDir);
            checkOutput("model meas_req", 32'(bus.meas_req), mReq);
            checkOutput("model angle", 32'(bus.angle), mAngle);
            checkOutput("model angle_valid", 32'(bus.angle_valid), mValid);
            checkOutput("model timeout", 32'(bus.timeout), mTimeout);
            checkOutput("model sweep_done", 32'(bus.sweep_done), mSweep);
        end
    end

    // Log of reported angles and sweep reversals for the directed checks.
    always @(negedge clk) begin
        if (compareOn) begin
            if (bus.angle_valid === 1'b1) angleLog.push_back(int'(bus.angle));
            if (bus.sweep_done === 1'b1) sweepCount++;
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int expAngles[5];
        int n;
        int high;
        int toCnt;
        int vCnt;
        int reqSeen;
        int prevAngle;
        int prevPos;
        int holdPos;
        int logBase;
        int diff;

        expAngles = '{0, 2, 4, 2, 0};

        #1 rst = 1'b1;
        tick(2);
        rst = 1'b0;
        compareOn = 1'b1;

        checkOutput("reset pos", 32'(bus.pos), 0);
        checkOutput("reset dir", 32'(bus.dir), 0);
        checkOutput("reset meas_req", 32'(bus.meas_req), 0);
        checkOutput("reset angle", 32'(bus.angle), 0);
        checkOutput("reset angle_valid", 32'(bus.angle_valid), 0);

        // full sweep with a responsive ranger
        applyStimulus(1'b1);
        n = 0;
        while (angleLog.size() < 5 && n < 200) begin
            @(negedge clk);
            n++;
        end
        tick(2);
        checkOutput("sweep angle count", angleLog.size(), 5);
        for (int i = 0; i < 5; i++) begin
            checkOutput($sformatf("sweep angle[%0d]", i), (i < angleLog.size()) ? angleLog[i] : -1, expAngles[i]);
        end
        checkOutput("sweep reversals", sweepCount, 2);

        // ranger never answers: request held for the full timeout
        respMode = 1;
        waitReq(1'b1, 50, "timeout req rise");
        prevAngle = int'(bus.angle);
        prevPos   = int'(bus.pos);
        high = 0; toCnt = 0; vCnt = 0;
        while (bus.meas_req === 1'b1 && high < 50) begin
            high++;
            @(negedge clk);
            toCnt += int'(bus.timeout);
            vCnt  += int'(bus.angle_valid);
        end
        checkOutput("timeout req cycles", high, TIMEOUT_CYC);
        checkOutput("timeout pulses", toCnt, 1);
        checkOutput("timeout valid pulses", vCnt, 0);
        checkOutput("timeout angle kept", 32'(bus.angle), prevAngle);
        tick(1);
        diff = int'(bus.pos) - prevPos;
        if (diff < 0) diff = -diff;
        checkOutput("timeout pos advanced", diff, STEP);

        // done arrives on the very edge the timeout would fire
        respMode  = 0;
        respDelay = TIMEOUT_CYC;
        waitReq(1'b1, 50, "coincide req rise");
        prevPos = int'(bus.pos);
        high = 0; toCnt = 0; vCnt = 0;
        while (bus.meas_req === 1'b1 && high < 50) begin
            high++;
            @(negedge clk);
            toCnt += int'(bus.timeout);
            vCnt  += int'(bus.angle_valid);
        end
        checkOutput("coincide req cycles", high, TIMEOUT_CYC);
        checkOutput("coincide valid", vCnt, 1);
        checkOutput("coincide timeout", toCnt, 0);
        checkOutput("coincide angle", 32'(bus.angle), prevPos);

        // enable dropped during settle
        respDelay = 2;
        applyStimulus(1'b0);
        tick(1);
        holdPos = int'(bus.pos);
        reqSeen = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            reqSeen += int'(bus.meas_req);
        end
        checkOutput("idle no request", reqSeen, 0);
        checkOutput("idle pos held", 32'(bus.pos), holdPos);
        logBase = angleLog.size();
        applyStimulus(1'b1);
        n = 0;
        while (angleLog.size() == logBase && n < 50) begin
            @(negedge clk);
            n++;
        end
        checkOutput("resume angle", (angleLog.size() > logBase) ? angleLog[logBase] : -1, holdPos);

        // enable dropped during a measurement
        waitReq(1'b1, 50, "meas drop req rise");
        applyStimulus(1'b0);
        vCnt = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            vCnt += int'(bus.angle_valid);
        end
        holdPos = int'(bus.pos);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            vCnt += int'(bus.angle_valid);
        end
        checkOutput("meas drop valid", vCnt, 1);
        checkOutput("meas drop req low", 32'(bus.meas_req), 0);
        checkOutput("meas drop pos held", 32'(bus.pos), holdPos);

        // reset while a request is outstanding at the top end point
        respMode = 1;
        applyStimulus(1'b1);
        n = 0;
        while (!(bus.meas_req === 1'b1 && int'(bus.pos) == POS_MAX) && n < 400) begin
            @(negedge clk);
            n++;
        end
        checkOutput("reach top with req", 32'(bus.pos), POS_MAX);
        #2 rst = 1'b1;
        #1;
        checkOutput("async rst meas_req", 32'(bus.meas_req), 0);
        checkOutput("async rst pos", 32'(bus.pos), POS_MIN);
        checkOutput("async rst dir", 32'(bus.dir), 0);
        checkOutput("async rst angle_valid", 32'(bus.angle_valid), 0);
        checkOutput("async rst timeout", 32'(bus.timeout), 0);
        checkOutput("async rst sweep_done", 32'(bus.sweep_done), 0);
        tick(2);
        rst = 1'b0;
        respMode = 0;
        logBase = angleLog.size();
        n = 0;
        while (angleLog.size() == logBase && n < 50) begin
            @(negedge clk);
            n++;
        end
        checkOutput("post reset first angle", (angleLog.size() > logBase) ? angleLog[logBase] : -1, POS_MIN);

        // stray done pulses while idle
        applyStimulus(1'b0);
        tick(20);
        holdPos = int'(bus.pos);
        respMode = 3;
        vCnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            vCnt += int'(bus.angle_valid);
        end
        checkOutput("idle stray valid", vCnt, 0);
        checkOutput("idle stray pos", 32'(bus.pos), holdPos);

        // randomized enable with random done noise
        repeat (100) begin
            applyStimulus($urandom_range(0, 3) != 0);
            @(negedge clk);
            checkOutput("random pos even", 32'(bus.pos % 2), 0);
            checkOutput("random pos range", 32'(int'(bus.pos) <= POS_MAX), 1);
        end

        compareOn = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
        $finish;
    end

endmodule

// File: doc/servo_scan.md
Name: servo_scan

Overview:
- Sweep controller that sits directly upstream of the servo PWM block and drives its `pos` input.
- Steps the angle back and forth between POS_MIN and POS_MAX.
- At each angle it waits a settle time, then performs a request/done handshake with the ranging unit.
- Emits the angle tagged to each completed measurement, for the display/report path.

Parameters:
- POS_LEN, 8, width of pos/angle (matches servo POS_LEN).
- POS_MIN, 0, lower sweep end point.
- POS_MAX, 180, upper sweep end point; legal only if POS_MAX < 2^POS_LEN and POS_MAX-POS_MIN >= STEP.
- STEP, 1, angle increment per step; must be >= 1.
- CNT_LEN, 24, width of settle/timeout counter.
- SETTLE_CYC, 5000000, clk cycles spent in SETTLE after each move; must be >= 1.
- TIMEOUT_CYC, 2500000, maximum clk cycles spent in MEAS awaiting meas_done; must be >= 1.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- en  in  1  scan enable
- meas_done  in  1  ranging unit completion; meaningful only in MEAS
- pos  out  POS_LEN  commanded angle, registered
- dir  out  1  0 = increasing, 1 = decreasing
- meas_req  out  1  measurement request, level, registered
- angle  out  POS_LEN  angle of last completed measurement
- angle_valid  out  1  one-cycle pulse, angle updated
- timeout  out  1  one-cycle pulse, measurement abandoned
- sweep_done  out  1  one-cycle pulse on each end-point reversal

Behaviour:
- Reset (async, any state): state=IDLE, pos=POS_MIN, dir=0, angle=0, cnt=0, all pulse outputs and meas_req = 0.
- All outputs are registered; no combinational input-to-output path.
- IDLE: pos and dir hold. If en=1 → SETTLE with cnt=0.
- SETTLE:
  - en=0 → IDLE on the next edge.
  - Otherwise cnt increments.
  - When cnt == SETTLE_CYC-1 → MEAS, cnt=0, meas_req=1 on that same edge.
  - Settle length is exactly SETTLE_CYC cycles.
- MEAS:
  - meas_req held at 1 for the whole state; en is ignored here, so a handshake is never aborted.
  - meas_done=1 sampled: meas_req=0, angle=pos, angle_valid=1 for one cycle, → STEP.
  - Else if cnt == TIMEOUT_CYC-1: meas_req=0, timeout=1 for one cycle, angle unchanged, → STEP.
  - If meas_done and timeout coincide, meas_done wins and timeout stays 0.
  - meas_done outside MEAS is ignored.
  - A meas_done already high on the cycle meas_req rises counts only from the first MEAS cycle onward, i.e. sampled at the first edge in MEAS.
- STEP (one cycle), with arithmetic in POS_LEN+1 bits so no wrap-around:
  - dir=0: if pos+STEP <= POS_MAX, pos += STEP; else dir=1, pos -= STEP, sweep_done=1.
  - dir=1: if pos >= POS_MIN+STEP, pos -= STEP; else dir=0, pos += STEP, sweep_done=1.
  - End points are therefore visited once per reversal, not twice. pos never leaves [POS_MIN, POS_MAX].
  - Exit: en=1 → SETTLE with cnt=0; en=0 → IDLE.
- Per-angle period with an immediate done: SETTLE_CYC + 1 (MEAS) + 1 (STEP) cycles.
- Reset mid-MEAS drops meas_req to 0 asynchronously. The ranging unit must tolerate a request withdrawn without done.

Test Plan (params POS_MIN=0, POS_MAX=4, STEP=2, SETTLE_CYC=3, TIMEOUT_CYC=8, ranger model answers done 2 cycles after req):
- Reset then en=1 held → pos sequence 0,2,4,2,0,2… with 3 SETTLE cycles before each meas_req rise. angle_valid pulses carry angle=0,2,4,2,0. sweep_done pulses in the STEP after angle 4 and again after angle 0.
- meas_done held 0 → meas_req high exactly 8 cycles; timeout pulses once; angle_valid stays 0; angle keeps its previous value; pos then advances by 2.
- Assert meas_done on the same edge the timeout counter reaches 7 → angle_valid=1, timeout=0.
- Drop en mid-SETTLE → IDLE next cycle with pos unchanged and no meas_req. Drop en mid-MEAS → meas_req stays high until done, one STEP occurs, then IDLE. Re-assert en → resumes from the held pos and dir.
- Assert rst while meas_req=1 at pos=4 → meas_req, angle_valid, timeout and sweep_done go 0 immediately; pos=0, dir=0. The first scan after release starts at 0.
- Stray meas_done pulses during IDLE/SETTLE/STEP → no angle_valid, no state change; 100-cycle random en/done run → pos always even and within 0..4.
